// File: rtl/warp_xwb_if.sv
// warp_xwb_if: result/handshake bundle for the integer writeback collector.
// Carries ALU, MUL and DIV results in, and the rd1/rd2 writes, div_ready, pending and collision out.
interface warp_xwb_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_alu_valid;
    logic [4:0]    i_alu_rd;
    logic [63:0]   i_alu_data;
    logic          i_mul_valid;
    logic [4:0]    i_mul_rd;
    logic [63:0]   i_mul_data;
    logic          i_div_valid;
    logic          o_div_ready;
    logic [4:0]    i_div_rd;
    logic [63:0]   i_div_data;
    logic          o_rd1_wen;
    logic [4:0]    o_rd1_addr;
    logic [63:0]   o_rd1_wdata;
    logic          o_rd2_wen;
    logic [4:0]    o_rd2_addr;
    logic [63:0]   o_rd2_wdata;
    logic [CW-1:0] o_div_pending;
    logic          o_collision;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_mul_valid, i_mul_rd, i_mul_data,
        output i_div_valid, i_div_rd, i_div_data,
        input  o_div_ready,
        input  o_rd1_wen, o_rd1_addr, o_rd1_wdata,
        input  o_rd2_wen, o_rd2_addr, o_rd2_wdata,
        input  o_div_pending, o_collision
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_mul_valid, i_mul_rd, i_mul_data,
        input  i_div_valid, i_div_rd, i_div_data,
        output o_div_ready,
        output o_rd1_wen, o_rd1_addr, o_rd1_wdata,
        output o_rd2_wen, o_rd2_addr, o_rd2_wdata,
        output o_div_pending, o_collision
    );
endinterface

// File: rtl/warp_xwb.sv
// warp_xwb: merges ALU, MUL and DIV results onto register file ports rd1/rd2.
// Ports: i_clk, i_rst_n (async, active low), bus (warp_xwb_if.slave).
module warp_xwb #(
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    warp_xwb_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [63:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          r_rd1_wen;
    logic [4:0]    r_rd1_addr;
    logic [63:0]   r_rd1_wdata;
    logic          r_rd2_wen;
    logic [4:0]    r_rd2_addr;
    logic [63:0]   r_rd2_wdata;
    logic          r_collision;

    logic          w_ready;
    logic          w_empty;
    logic          w_alu_eff;
    logic          w_mul_eff;
    logic          w_div_acc;
    logic          w_div_eff;
    logic          w_col;
    logic          w_cand_v;
    logic [4:0]    w_cand_rd;
    logic [63:0]   w_cand_data;
    logic          w_take1;
    logic          w_take2;
    logic          w_pop;
    logic          w_push;

    logic          w_n_wen1;
    logic [4:0]    w_n_addr1;
    logic [63:0]   w_n_data1;
    logic          w_n_wen2;
    logic [4:0]    w_n_addr2;
    logic [63:0]   w_n_data2;

    // Ready comes only from the registered count so it never
    // combinationally depends on this cycle's drain.
    assign w_ready   = (r_count < CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_alu_eff = bus.i_alu_valid && (bus.i_alu_rd != 5'd0);
    assign w_mul_eff = bus.i_mul_valid && (bus.i_mul_rd != 5'd0);
    assign w_div_acc = bus.i_div_valid && w_ready;
    assign w_div_eff = w_div_acc && (bus.i_div_rd != 5'd0);
    assign w_col     = w_alu_eff && w_mul_eff &&
                       (bus.i_alu_rd == bus.i_mul_rd);

    // Head of FIFO first; bypass the incoming result only when empty.
    assign w_cand_v    = !w_empty || w_div_eff;
    assign w_cand_rd   = w_empty ? bus.i_div_rd   : r_mem_rd[r_rd_ptr];
    assign w_cand_data = w_empty ? bus.i_div_data : r_mem_data[r_rd_ptr];

    // On a collision MUL still owns port 2, so the candidate cannot use it.
    assign w_take1 = w_cand_v && !w_alu_eff;
    assign w_take2 = w_cand_v && !w_mul_eff && !w_take1;
    assign w_pop   = (w_take1 || w_take2) && !w_empty;
    assign w_push  = w_div_eff && !(w_empty && (w_take1 || w_take2));

    always_comb begin
        w_n_wen1  = 1'b0;
        w_n_addr1 = 5'd0;
        w_n_data1 = 64'd0;
        w_n_wen2  = 1'b0;
        w_n_addr2 = 5'd0;
        w_n_data2 = 64'd0;
        if (w_alu_eff) begin
            w_n_wen1  = 1'b1;
            w_n_addr1 = bus.i_alu_rd;
            w_n_data1 = bus.i_alu_data;
        end else if (w_take1) begin
            w_n_wen1  = 1'b1;
            w_n_addr1 = w_cand_rd;
            w_n_data1 = w_cand_data;
        end
        if (w_mul_eff && !w_col) begin
            w_n_wen2  = 1'b1;
            w_n_addr2 = bus.i_mul_rd;
            w_n_data2 = bus.i_mul_data;
        end else if (w_take2) begin
            w_n_wen2  = 1'b1;
            w_n_addr2 = w_cand_rd;
            w_n_data2 = w_cand_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= bus.i_div_rd;
            r_mem_data[r_wr_ptr] <= bus.i_div_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_rd1_wen   <= 1'b0;
            r_rd1_addr  <= 5'd0;
            r_rd1_wdata <= 64'd0;
            r_rd2_wen   <= 1'b0;
            r_rd2_addr  <= 5'd0;
            r_rd2_wdata <= 64'd0;
            r_collision <= 1'b0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count     <= r_count + CW'(w_push) - CW'(w_pop);
            r_rd1_wen   <= w_n_wen1;
            r_rd1_addr  <= w_n_addr1;
            r_rd1_wdata <= w_n_data1;
            r_rd2_wen   <= w_n_wen2;
            r_rd2_addr  <= w_n_addr2;
            r_rd2_wdata <= w_n_data2;
            r_collision <= w_col;
        end
    end

    assign bus.o_div_ready   = w_ready;
    assign bus.o_div_pending = r_count;
    assign bus.o_rd1_wen     = r_rd1_wen;
    assign bus.o_rd1_addr    = r_rd1_addr;
    assign bus.o_rd1_wdata   = r_rd1_wdata;
    assign bus.o_rd2_wen     = r_rd2_wen;
    assign bus.o_rd2_addr    = r_rd2_addr;
    assign bus.o_rd2_wdata   = r_rd2_wdata;
    assign bus.o_collision   = r_collision;
endmodule

// File: tb/tb_warp_xwb.sv
// tb_warp_xwb: directed plus random stimulus for warp_xwb.
// Checks every cycle against a queue-based model of the writeback rules.
module tb_warp_xwb;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    warp_xwb_if #(.DEPTH(DEPTH)) bus();

    warp_xwb #(.DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    res_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   acc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_alu_valid = 1'b0; bus.i_alu_rd = 5'd0; bus.i_alu_data = 64'd0;
        bus.i_mul_valid = 1'b0; bus.i_mul_rd = 5'd0; bus.i_mul_data = 64'd0;
        bus.i_div_valid = 1'b0; bus.i_div_rd = 5'd0; bus.i_div_data = 64'd0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wen1"}, 64'(bus.o_rd1_wen), 64'd0);
        chk({tag, "_wen2"}, 64'(bus.o_rd2_wen), 64'd0);
        chk({tag, "_ready"}, 64'(bus.o_div_ready), 64'd1);
        chk({tag, "_pend"}, 64'(bus.o_div_pending), 64'd0);
        chk({tag, "_col"}, 64'(bus.o_collision), 64'd0);
    endtask

    // One clock: drive inputs, predict, step, compare.
    task automatic cyc(input logic av, input logic [4:0] ard,
                       input logic [63:0] ad,
                       input logic mv, input logic [4:0] mrd,
                       input logic [63:0] md,
                       input logic dv, input logic [4:0] drd,
                       input logic [63:0] dd);
        bit ready, ae, me, col, e1, e2;
        logic [4:0] a1, a2;
        logic [63:0] d1, d2;
        res_t r;
        bus.i_alu_valid = av; bus.i_alu_rd = ard; bus.i_alu_data = ad;
        bus.i_mul_valid = mv; bus.i_mul_rd = mrd; bus.i_mul_data = md;
        bus.i_div_valid = dv; bus.i_div_rd = drd; bus.i_div_data = dd;
        ready = (q.size() < DEPTH);
        chk("div_ready", 64'(bus.o_div_ready), 64'(ready));
        chk("pending", 64'(bus.o_div_pending), 64'(q.size()));
        acc = dv && ready;
        ae  = av && (ard != 0);
        me  = mv && (mrd != 0);
        col = ae && me && (ard == mrd);
        e1 = 0; e2 = 0; a1 = 0; a2 = 0; d1 = 0; d2 = 0;
        if (ae) begin e1 = 1; a1 = ard; d1 = ad; end
        if (me && !col) begin e2 = 1; a2 = mrd; d2 = md; end
        if (acc && drd != 0) begin
            r.rd = drd; r.d = dd;
            q.push_back(r);
        end
        if (q.size() > 0 && !ae) begin
            e1 = 1; a1 = q[0].rd; d1 = q[0].d;
            void'(q.pop_front());
        end else if (q.size() > 0 && !me) begin
            e2 = 1; a2 = q[0].rd; d2 = q[0].d;
            void'(q.pop_front());
        end
        @(posedge clk);
        #1;
        chk("rd1_wen", 64'(bus.o_rd1_wen), 64'(e1));
        if (e1) begin
            chk("rd1_addr", 64'(bus.o_rd1_addr), 64'(a1));
            chk("rd1_data", bus.o_rd1_wdata, d1);
        end
        chk("rd2_wen", 64'(bus.o_rd2_wen), 64'(e2));
        if (e2) begin
            chk("rd2_addr", 64'(bus.o_rd2_addr), 64'(a2));
            chk("rd2_data", bus.o_rd2_wdata, d2);
        end
        chk("collision", 64'(bus.o_collision), 64'(col));
    endtask

    initial begin
        int idx;
        bit have;
        logic [4:0]  ord;
        logic [63:0] odat;

        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst_n = 1'b1;

        // Two independent results on both ports.
        cyc(1, 5, 64'h1234, 1, 6, 64'hABCD, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Divider bypass into port 1 with empty FIFO.
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 64'h55);
        chk("bypass_pend", 64'(bus.o_div_pending), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill FIFO while both ports are busy, then drain via port 1.
        idx = 10;
        for (int c = 0; c < 7; c++) begin
            cyc(1, 1, 64'(100 + c), 1, 2, 64'(200 + c),
                1, 5'(idx), 64'(idx * 16));
            if (acc) idx++;
        end
        chk("fill_pend", 64'(bus.o_div_pending), 64'd4);
        chk("fill_ready", 64'(bus.o_div_ready), 64'd0);
        chk("fill_idx", 64'(idx), 64'd14);
        for (int c = 0; c < 12; c++) begin
            if (idx <= 14) begin
                cyc(0, 0, 0, 1, 2, 64'(300 + c),
                    1, 5'(idx), 64'(idx * 16));
                if (acc) idx++;
            end else begin
                cyc(0, 0, 0, 1, 2, 64'(300 + c), 0, 0, 0);
            end
        end
        chk("drain_done", 64'(bus.o_div_pending), 64'd0);

        // x0 filtering on ALU, MUL and DIV.
        cyc(1, 0, 64'hDEAD, 0, 0, 0, 1, 9, 64'h99);
        cyc(0, 0, 0, 1, 0, 64'hBEEF, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 64'h77);

        // Same-rd collision.
        cyc(1, 3, 64'h11, 1, 3, 64'h22, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with three pending entries discards them.
        for (int c = 0; c < 3; c++)
            cyc(1, 1, 64'(c), 1, 2, 64'(c), 1, 5'(20 + c), 64'(c));
        chk("pre_rst_pend", 64'(bus.o_div_pending), 64'd3);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk_reset_state("midrst");
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; divider holds its offer until accepted.
        have = 0; ord = 0; odat = 0;
        for (int c = 0; c < 3000; c++) begin
            logic av, mv;
            logic [4:0] ard, mrd;
            if (!have && $urandom_range(0, 3) != 0) begin
                have = 1;
                ord  = 5'($urandom_range(0, 15));
                odat = {$urandom, $urandom};
            end
            av  = ($urandom_range(0, 99) < 55);
            mv  = ($urandom_range(0, 99) < 55);
            ard = 5'($urandom_range(0, 7));
            mrd = 5'($urandom_range(0, 7));
            cyc(av, ard, {$urandom, $urandom}, mv, mrd, {$urandom, $urandom},
                have, ord, odat);
            if (acc) have = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/warp_xwb.md
Name: warp_xwb

Overview:
- Scalar integer writeback collector; merges results from the fixed-latency ALU path, the multiplier and the variable-latency divider onto the two integer register file write ports (rd1/rd2).
- The divider has no guaranteed writeback slot, so its results are held in a small in-order pending FIFO. The FIFO drains into whichever write port is idle.
- Backpressure to the divider uses a valid/ready handshake. ALU and multiplier results are never stalled.

Parameters:
- DEPTH, 4, pending divider-result FIFO entries; power of two, >= 2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_alu_valid  in  1  ALU/shift/logic result valid; cannot be stalled
- i_alu_rd  in  5  destination register
- i_alu_data  in  64  result, already sign-extended for word ops
- i_mul_valid  in  1  multiplier result valid; cannot be stalled
- i_mul_rd  in  5  destination register
- i_mul_data  in  64  result
- i_div_valid  in  1  divider result offered
- o_div_ready  out  1  result accepted when valid && ready
- i_div_rd  in  5  destination register (quotient or remainder, selected upstream)
- i_div_data  in  64  result
- o_rd1_wen  out  1  write enable, register file port 1
- o_rd1_addr  out  5  write address, port 1
- o_rd1_wdata  out  64  write data, port 1
- o_rd2_wen  out  1  write enable, register file port 2
- o_rd2_addr  out  5  write address, port 2
- o_rd2_wdata  out  64  write data, port 2
- o_div_pending  out  clog2(DEPTH)+1  FIFO occupancy
- o_collision  out  1  one-cycle pulse: ALU/MUL same-rd conflict

Behaviour:
- Reset:
  - All outputs are 0 except o_div_ready = 1.
  - FIFO is emptied and pointers are cleared.
  - Asserting reset mid-operation discards all pending results; no write is issued for them.
- Latency:
  - Inputs are sampled on a rising edge; the corresponding write appears on the registered o_rd* outputs in the following cycle.
  - Each wen is high for exactly one cycle per result.
- x0 filter:
  - Any source with rd == 0 is treated as not valid: no write, no port occupied.
  - A divider result with rd == 0 is still accepted when ready, then discarded (not enqueued).
- Port 1 owner: effective ALU result; else the drain candidate.
- Port 2 owner: effective MUL result; else the drain candidate, if port 1 did not take it.
- Drain candidate:
  - FIFO head if the FIFO is non-empty.
  - Else the accepted incoming divider result (bypass, not enqueued).
  - At most one divider result is written per cycle.
- Ordering: if the FIFO is non-empty, an accepted divider result is always enqueued behind the head, never bypassed. Divider results are written in acceptance order.
- Occupancy updates:
  - Drain and enqueue in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- o_div_ready:
  - Equals (o_div_pending < DEPTH), derived from the registered count only.
  - It is not a function of same-cycle drain or of i_div_valid.
  - When full, the divider holds its result until ready returns.
- Collision:
  - Applies when ALU and MUL are both effective with equal rd.
  - Port 1 writes the ALU result; the port 2 write is suppressed (wen 0).
  - o_collision = 1 for one cycle.
  - A drain candidate never takes port 2 in that cycle.
- Hazards: the scoreboard guarantees no WAW between pending divider results and ALU/MUL results. This block does not check it.
- Width rules: data passes through unmodified; sign extension is the producing unit's responsibility.

Test Plan:
- Reset, then release; hold reset with 3 pending entries -> all wen 0, o_div_ready = 1, o_div_pending = 0, and no writes after release.
- ALU rd=5 data=0x1234 and MUL rd=6 data=0xABCD in the same cycle -> next cycle rd1 = (5, 0x1234) and rd2 = (6, 0xABCD), both wen = 1 for one cycle.
- ALU and MUL idle, FIFO empty, divider rd=7 data=0x55 -> next cycle rd1 = (7, 0x55); o_div_pending stays 0 (bypass).
- ALU rd=1 and MUL rd=2 valid every cycle while the divider offers rd 10..14:
  - 10..13 are accepted; o_div_pending reaches 4 and o_div_ready drops to 0; rd 14 is held.
  - Then drop ALU valid -> rd1 writes 10, 11, 12, 13 in consecutive cycles.
  - o_div_ready returns to 1 the cycle after the first drain; rd 14 is accepted and written last.
- ALU valid with rd=0 plus divider rd=9 -> divider result is written on port 1. MUL rd=0 valid -> rd2 wen = 0.
- ALU and MUL both rd=3, data 0x11 / 0x22 -> rd1 = (3, 0x11), rd2 wen = 0, o_collision = 1 for exactly one cycle.
